register_file: RTL and testbench
================================

# register_file

Architectural register file with rename tags for the out-of-order core. It holds the 32 committed integer registers plus, per register, a busy bit and the reorder-buffer entry that will produce its next value. It is written at issue (rename) and at commit (value retire) by the reorder buffer's commit broadcast. It is read combinationally by the decoder/issue logic to obtain source operands or the tags to wait on.

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers; x0 is hard-wired zero.
- ENTRY_W, 5, width of a reorder-buffer entry index (32-entry ROB).

Ports:
- clk_in  in  1  system clock; all state updates on rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- rdy_in  in  1  pause when low; no state change, reads still valid.
- roll_back  in  1  misprediction flush from reorder buffer; clears all rename state.
- issue_valid  in  1  an instruction with a destination is being issued this cycle.
- issue_rd  in  5  destination register of the issuing instruction.
- issue_entry  in  ENTRY_W  ROB entry allocated to the issuing instruction.
- rob_commit  in  1  commit broadcast valid.
- commit_we  in  1  committing instruction writes a register (low for store/branch).
- rob_des_commit  in  5  destination register of the committing instruction.
- rob_entry_commit  in  ENTRY_W  ROB entry of the committing instruction.
- rob_result_in  in  32  value being committed.
- rs1_addr, rs2_addr  in  5 each  source register indices.
- rs1_value, rs2_value  out  32 each  register value (valid when busy low).
- rs1_busy, rs2_busy  out  1 each  operand not yet available; wait on tag.
- rs1_tag, rs2_tag  out  ENTRY_W each  ROB entry producing the operand.

## Operation
- State per register i: value[i] (32b), busy[i] (1b), tag[i] (ENTRY_W).
- Commit write: when rdy_in && rob_commit && commit_we && rob_des_commit != 0, value[rob_des_commit] <= rob_result_in. If additionally busy[rd] && tag[rd] == rob_entry_commit, busy[rd] <= 0. A tag mismatch means a younger rename exists; busy/tag are left unchanged.
- Rename: when rdy_in && issue_valid && issue_rd != 0 && !roll_back, busy[issue_rd] <= 1 and tag[issue_rd] <= issue_entry.
- Same-register collision: if a commit and a rename target the same register in one cycle, the value is written, and busy=1 with tag=issue_entry wins.
- Roll back: when rdy_in && roll_back, all busy bits are cleared and the issue input is ignored. A commit write in the same cycle is still applied to the value.
- x0: value 0, busy 0, tag 0 always. Writes and renames to x0 are discarded.
- Read path (combinational, per source port) is evaluated on pre-edge state:
  - addr == 0: value 0, busy 0, tag 0.
  - Commit bypass: if rob_commit && commit_we && rob_des_commit == addr && busy[addr] && tag[addr] == rob_entry_commit, then value = rob_result_in, busy = 0.
  - Otherwise: value[addr], busy[addr], tag[addr].
  - A rename in the same cycle does not affect the read. The issuing instruction reads its sources before its own rd is renamed.
  - The bypass applies regardless of rdy_in.

## Timing
- Reset (async, rst_in high): all value, busy, and tag cleared to 0 immediately. Outputs then read 0/0/0 for every address. Reset mid-operation discards any pending rename or commit.
- Write latency: commit and rename take effect at the next rising edge. Commit value is visible the same cycle via bypass.
- Read latency: zero cycles, purely combinational from addr and commit inputs.
- rdy_in low: registers hold, including across roll_back or commit asserted during the pause.
- Two reads and one commit plus one rename per cycle. No back-pressure, no internal FSM beyond per-register busy state.

## Test plan
- Reset, then read x5 and x0 -> value 0, busy 0, tag 0. Commit 0xDEADBEEF to x0 -> x0 still reads 0.
- Rename x3 to entry 7, next cycle read rs1=x3 -> busy 1, tag 7. Commit x3/entry 7/0x1234 -> same cycle rs1_value 0x1234 busy 0, and next cycle stored value 0x1234 busy 0.
- Rename x4 to entry 2, then rename x4 to entry 9. Commit x4/entry 2/0x55 -> value 0x55, but busy stays 1 with tag 9. Commit entry 9/0x66 -> busy 0, value 0x66.
- Same-cycle commit x6/entry 1/0xAA (tag matches) plus rename x6 to entry 12 -> next cycle value 0xAA, busy 1, tag 12. A read of x6 during that cycle shows value 0xAA, busy 0.
- Rename x1, x2, x3 (entries 3, 4, 5), then roll_back together with issue x7 to entry 6 -> next cycle all busy 0, x7 not renamed, values unchanged.
- With rdy_in low, rename x8 and commit x9 -> no state change. Assert rst_in asynchronously mid-cycle after renames -> outputs clear before the next edge.

Source files
------------

// File: rtl/register_file.sv
// register_file: committed integer registers with per-register rename busy/tag state
module register_file #(
  parameter int REG_NUM = 32,
  parameter int ENTRY_W = 5
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               roll_back,
  input  logic               issue_valid,
  input  logic [4:0]         issue_rd,
  input  logic [ENTRY_W-1:0] issue_entry,
  input  logic               rob_commit,
  input  logic               commit_we,
  input  logic [4:0]         rob_des_commit,
  input  logic [ENTRY_W-1:0] rob_entry_commit,
  input  logic [31:0]        rob_result_in,
  input  logic [4:0]         rs1_addr,
  input  logic [4:0]         rs2_addr,
  output logic [31:0]        rs1_value,
  output logic [31:0]        rs2_value,
  output logic               rs1_busy,
  output logic               rs2_busy,
  output logic [ENTRY_W-1:0] rs1_tag,
  output logic [ENTRY_W-1:0] rs2_tag
);
  logic [31:0]        value [REG_NUM];
  logic [ENTRY_W-1:0] tag   [REG_NUM];
  logic [REG_NUM-1:0] busy;
  logic               commit_wr;
  logic               commit_match;
  logic               byp1;
  logic               byp2;
  assign commit_wr    = rob_commit && commit_we && rob_des_commit != 5'd0;
  assign commit_match = busy[rob_des_commit] && tag[rob_des_commit] == rob_entry_commit;
  // x0 is never written, so its reset-time zero state persists
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        value[i] <= '0;
        tag[i]   <= '0;
      end
      busy <= '0;
    end else if (rdy_in) begin
      if (commit_wr) value[rob_des_commit] <= rob_result_in;
      if (roll_back) busy <= '0;
      else begin
        if (commit_wr && commit_match) busy[rob_des_commit] <= 1'b0;
        if (issue_valid && issue_rd != 5'd0) begin
          busy[issue_rd] <= 1'b1;
          tag[issue_rd]  <= issue_entry;
        end
      end
    end
  end
  // bypass only when the commit retires the producer the reader would wait on
  always_comb begin
    byp1      = rob_commit && commit_we && rob_des_commit == rs1_addr && busy[rs1_addr] && tag[rs1_addr] == rob_entry_commit;
    byp2      = rob_commit && commit_we && rob_des_commit == rs2_addr && busy[rs2_addr] && tag[rs2_addr] == rob_entry_commit;
    rs1_value = rs1_addr == 5'd0 ? 32'd0 : byp1 ? rob_result_in : value[rs1_addr];
    rs2_value = rs2_addr == 5'd0 ? 32'd0 : byp2 ? rob_result_in : value[rs2_addr];
    rs1_busy  = rs1_addr != 5'd0 && !byp1 && busy[rs1_addr];
    rs2_busy  = rs2_addr != 5'd0 && !byp2 && busy[rs2_addr];
    rs1_tag   = rs1_addr == 5'd0 ? '0 : tag[rs1_addr];
    rs2_tag   = rs2_addr == 5'd0 ? '0 : tag[rs2_addr];
  end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: scoreboard bench for register_file rename/commit/bypass behaviour
module tb_register_file;
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        roll_back;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_entry;
  logic        rob_commit;
  logic        commit_we;
  logic [4:0]  rob_des_commit;
  logic [4:0]  rob_entry_commit;
  logic [31:0] rob_result_in;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_value;
  logic [31:0] rs2_value;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [4:0]  rs1_tag;
  logic [4:0]  rs2_tag;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string       name;
    bit          port;
    logic [37:0] exp;
  } sb_t;
  sb_t sb[$];
  register_file dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_entry(issue_entry),
    .rob_commit(rob_commit), .commit_we(commit_we), .rob_des_commit(rob_des_commit),
    .rob_entry_commit(rob_entry_commit), .rob_result_in(rob_result_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag)
  );
  always #5 clk_in = ~clk_in;
  task automatic check(input string name, input logic [37:0] obs, input logic [37:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got value=%h busy=%b tag=%0d, want value=%h busy=%b tag=%0d",
               name, obs[37:6], obs[5], obs[4:0], exp[37:6], exp[5], exp[4:0]);
    end
  endtask
  task automatic rd(input string name, input bit port, input logic [4:0] addr,
                    input logic [31:0] v, input logic b, input logic [4:0] t);
    sb_t e;
    if (port) rs2_addr = addr;
    else rs1_addr = addr;
    e.name = name;
    e.port = port;
    e.exp  = {v, b, t};
    sb.push_back(e);
  endtask
  task automatic drain();
    sb_t e;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, e.port ? {rs2_value, rs2_busy, rs2_tag} : {rs1_value, rs1_busy, rs1_tag}, e.exp);
    end
  endtask
  task automatic idle();
    roll_back = 0; issue_valid = 0; issue_rd = 0; issue_entry = 0;
    rob_commit = 0; commit_we = 0; rob_des_commit = 0; rob_entry_commit = 0; rob_result_in = 0;
  endtask
  task automatic tick();
    @(posedge clk_in);
    #1;
    idle();
  endtask
  task automatic issue(input logic [4:0] r, input logic [4:0] e);
    issue_valid = 1; issue_rd = r; issue_entry = e;
  endtask
  task automatic commit(input logic [4:0] r, input logic [4:0] e, input logic [31:0] v);
    rob_commit = 1; commit_we = 1; rob_des_commit = r; rob_entry_commit = e; rob_result_in = v;
  endtask
  initial begin
    rst_in = 1; rdy_in = 1; rs1_addr = 0; rs2_addr = 0;
    idle();
    repeat (2) @(posedge clk_in);
    #1 rst_in = 0;
    rd("reset_x5", 0, 5, 0, 0, 0); rd("reset_x0", 1, 0, 0, 0, 0); drain();
    commit(0, 0, 32'hDEADBEEF);
    rd("x0_during_commit", 0, 0, 0, 0, 0); drain();
    tick();
    rd("x0_after_commit", 1, 0, 0, 0, 0); drain();
    issue(3, 7); tick();
    rd("x3_renamed", 0, 3, 0, 1, 7); drain();
    commit(3, 7, 32'h1234);
    rd("x3_bypass", 0, 3, 32'h1234, 0, 7); drain();
    tick();
    rd("x3_committed", 0, 3, 32'h1234, 0, 7); drain();
    issue(4, 2); tick();
    issue(4, 9); tick();
    commit(4, 2, 32'h55);
    rd("x4_stale_no_bypass", 1, 4, 0, 1, 9); drain();
    tick();
    rd("x4_stale_commit", 1, 4, 32'h55, 1, 9); drain();
    commit(4, 9, 32'h66);
    rd("x4_match_bypass", 1, 4, 32'h66, 0, 9); drain();
    tick();
    rd("x4_match_commit", 1, 4, 32'h66, 0, 9); drain();
    issue(6, 1); tick();
    commit(6, 1, 32'hAA); issue(6, 12);
    rd("x6_collide_read", 0, 6, 32'hAA, 0, 1); drain();
    tick();
    rd("x6_collide_after", 0, 6, 32'hAA, 1, 12); drain();
    issue(1, 3); tick();
    issue(2, 4); tick();
    issue(3, 5); tick();
    roll_back = 1; issue(7, 6);
    rd("x1_before_rollback", 0, 1, 0, 1, 3); drain();
    tick();
    rd("x1_rolled", 0, 1, 0, 0, 3); rd("x2_rolled", 1, 2, 0, 0, 4); drain();
    rd("x3_rolled", 0, 3, 32'h1234, 0, 5); rd("x7_not_renamed", 1, 7, 0, 0, 0); drain();
    issue(6, 12); tick();
    rdy_in = 0; issue(8, 10); commit(9, 3, 32'h99);
    rd("x9_paused_no_bypass", 0, 9, 0, 0, 0); drain();
    tick();
    rdy_in = 1;
    rd("x8_paused", 0, 8, 0, 0, 0); rd("x9_paused", 1, 9, 0, 0, 0); drain();
    rdy_in = 0; commit(6, 12, 32'hBB);
    rd("x6_paused_bypass", 0, 6, 32'hBB, 0, 12); drain();
    tick();
    rdy_in = 1;
    rd("x6_paused_hold", 0, 6, 32'hAA, 1, 12); drain();
    issue(10, 11); tick();
    rd("x10_renamed", 0, 10, 0, 1, 11); drain();
    issue(11, 13);
    #1 rst_in = 1;
    rd("x10_async_reset", 0, 10, 0, 0, 0); rd("x6_async_reset", 1, 6, 0, 0, 0); drain();
    tick();
    #2 rst_in = 0;
    rd("x11_reset_discard", 0, 11, 0, 0, 0); rd("x4_reset_value", 1, 4, 0, 0, 0); drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
